icache: RTL and testbench
=========================

# icache

Direct-mapped, one-word-per-line instruction cache between the instruction fetcher and the memory controller. It serves fetcher requests from on-chip lines on a hit and, on a miss, issues one word request to the memory controller, fills the line and returns the instruction. Mispredict flushes cancel delivery of an in-flight request, but the memory transaction that is already started still completes.

## Interface
- INDEX_W, 8, index bits; number of lines = 2^INDEX_W; tag = pc[31:INDEX_W+2]
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when 0 all state holds
- iIF_en  in  1  fetch request; fetcher holds it with a stable pc until oIF_valid
- iIF_pc  in  32  fetch address; pc[1:0] are ignored
- iFlush  in  1  mispredict flush; drops any pending or in-flight delivery
- oIF_valid  out  1  one-cycle pulse: oIF_inst is valid
- oIF_inst  out  32  fetched instruction
- oMC_en  out  1  word-read request to memctrl; held until iMC_done
- oMC_addr  out  32  request address, {pc[31:2],2'b00}
- iMC_done  in  1  memctrl completion pulse
- iMC_inst  in  32  instruction returned by memctrl, valid with iMC_done

## Operation
- Storage: valid[2^INDEX_W], tag[2^INDEX_W], data[2^INDEX_W] (32 bits). Lookup index = pc[INDEX_W+1:2]. Hit = valid & tag match.
- States:
  - IDLE: if iIF_en & !iFlush: on a hit, latch data into oIF_inst and go to RESP. On a miss, latch the request address, set oMC_en=1, clear drop and go to MISS. With no request, or with iFlush=1, stay in IDLE.
  - MISS: hold oMC_en=1 and oMC_addr stable. iFlush=1 sets drop. On iMC_done: write valid=1, tag and data=iMC_inst at the latched index; set oMC_en=0. Then, if drop=1 or iFlush=1, go to IDLE with no delivery; otherwise latch iMC_inst into oIF_inst and go to RESP.
  - RESP: oIF_valid=1 for this cycle only. Any request seen in this cycle is ignored, because the fetcher's iIF_en is still high for the same pc. Go to IDLE next cycle.
- oIF_valid = (state==RESP) & rdy & !iFlush. A flush in the RESP cycle suppresses delivery, and the block still goes to IDLE.
- rdy=0: no register updates, oIF_valid forced 0. A pending RESP is delivered on the first cycle with rdy=1.
- Flush never invalidates lines. Self-modifying code is not supported.
- Only one outstanding memctrl request at a time. iMC_done seen outside MISS is ignored.

## Timing
- Reset values: state=IDLE, all valid bits=0, oIF_valid=0, oIF_inst=0, oMC_en=0, oMC_addr=0, drop=0.
- Hit latency: request sampled at edge N, oIF_valid high in cycle N+1. Hit throughput is one instruction per 2 cycles.
- Miss latency: request sampled at edge N, oMC_en high from cycle N+1. After iMC_done is sampled at edge M, oIF_valid is high in cycle M+1. Total = memctrl latency + 2 cycles.
- oMC_en deasserts on the edge that samples iMC_done, so memctrl sees en=0 when it returns to idle and starts no duplicate read.
- Flush in the same cycle as iMC_done: the line is filled and delivery is dropped.
- Reset asserted during MISS: returns to IDLE with oMC_en=0. Memctrl is reset by the same rst.

## Test plan
- Reset, then iIF_en with pc=0x0000_0004 (cold) -> oMC_en=1 with oMC_addr=0x4. Memctrl returns 0x0000_0013 -> oIF_valid pulses 1 cycle later with oIF_inst=0x0000_0013.
- Repeat the request for pc=0x4 -> no oMC_en; oIF_valid in cycle N+1 with 0x0000_0013.
- Conflict: with INDEX_W=8, pc=0x404 maps to the same index as 0x4 -> miss; the line is refilled with the new tag; a following fetch of 0x4 misses again.
- Flush during MISS (pc=0x100) -> oMC_en stays high until done; no oIF_valid; the next fetch of 0x100 hits.
- Hold rdy=0 for 3 cycles in RESP -> oIF_valid=0 during the stall and exactly one pulse after rdy returns to 1. Flush in the RESP cycle -> no pulse.
- pc=0x8 with pc[1:0] nonzero (0xB) -> oMC_addr=0x8, and the same line is used.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and
// the memory controller; a miss issues a single word read and fills the line.
module icache #(
  parameter int INDEX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        iIF_en,
  input  logic [31:0] iIF_pc,
  input  logic        iFlush,
  output logic        oIF_valid,
  output logic [31:0] oIF_inst,
  output logic        oMC_en,
  output logic [31:0] oMC_addr,
  input  logic        iMC_done,
  input  logic [31:0] iMC_inst
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MISS = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      inst_q, inst_d;
  logic             mc_en_q, mc_en_d;
  logic [31:0]      mc_addr_q, mc_addr_d;
  logic             drop_q, drop_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [INDEX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               hit;
  logic               fill_we;
  logic               unused_pc;

  assign req_idx   = iIF_pc[INDEX_W+1:2];
  assign req_tag   = iIF_pc[31:INDEX_W+2];
  assign fill_idx  = mc_addr_q[INDEX_W+1:2];
  assign fill_tag  = mc_addr_q[31:INDEX_W+2];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_pc = ^iIF_pc[1:0];

  assign oIF_valid = (state_q == S_RESP) && rdy && !iFlush;
  assign oIF_inst  = inst_q;
  assign oMC_en    = mc_en_q;
  assign oMC_addr  = mc_addr_q;

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    mc_en_d   = mc_en_q;
    mc_addr_d = mc_addr_q;
    drop_d    = drop_q;
    valid_d   = valid_q;
    fill_we   = 1'b0;
    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if (iIF_en && !iFlush) begin
            if (hit) begin
              inst_d  = data_q[req_idx];
              state_d = S_RESP;
            end else begin
              mc_addr_d = {iIF_pc[31:2], 2'b00};
              mc_en_d   = 1'b1;
              drop_d    = 1'b0;
              state_d   = S_MISS;
            end
          end
        end
        S_MISS: begin
          if (iFlush) drop_d = 1'b1;
          // The fill always lands, even when the delivery has been cancelled.
          if (iMC_done) begin
            fill_we           = 1'b1;
            valid_d[fill_idx] = 1'b1;
            mc_en_d           = 1'b0;
            if (drop_q || iFlush) begin
              state_d = S_IDLE;
            end else begin
              inst_d  = iMC_inst;
              state_d = S_RESP;
            end
          end
        end
        S_RESP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      inst_q    <= '0;
      mc_en_q   <= 1'b0;
      mc_addr_q <= '0;
      drop_q    <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      mc_en_q   <= mc_en_d;
      mc_addr_q <= mc_addr_d;
      drop_q    <= drop_d;
      valid_q   <= valid_d;
    end
  end

  // Tag and data arrays need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill_we && !rst) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iMC_inst;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a latency-based memctrl model feeds misses,
// and expected instructions are queued at request time and popped on delivery.
module tb_icache;

   localparam int MC_LAT = 3;

   logic        clk = 1'b0;
   logic        rst, rdy, iIF_en, iFlush, iMC_done;
   logic [31:0] iIF_pc, iMC_inst;
   logic        oIF_valid, oMC_en;
   logic [31:0] oIF_inst, oMC_addr;

   int          total = 0;
   int          bad = 0;
   int          mc_reqs = 0;
   int          valid_cnt = 0;
   int          mc_cnt = 0;
   logic [31:0] exp_mc_addr = '0;
   logic [31:0] mc_lat_addr = '0;
   logic [31:0] sb[$];

   icache #(.INDEX_W(8)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .iIF_en(iIF_en), .iIF_pc(iIF_pc), .iFlush(iFlush),
      .oIF_valid(oIF_valid), .oIF_inst(oIF_inst),
      .oMC_en(oMC_en), .oMC_addr(oMC_addr),
      .iMC_done(iMC_done), .iMC_inst(iMC_inst)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Backing memory contents: 0x4 holds the test-plan word, others are hashed
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h4) return 32'h0000_0013;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Every comparison in the bench goes through here and is counted
   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, act, exp);
      end
   endtask

   // Move to just after the next rising edge, where inputs are changed
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory controller model: accepts a read when idle and answers MC_LAT cycles later
   initial begin
      iMC_done = 1'b0;
      iMC_inst = '0;
      forever begin
         @(posedge clk);
         #2;
         iMC_done = 1'b0;
         if (rst) begin
            mc_cnt = 0;
         end else if (mc_cnt > 0) begin
            mc_cnt--;
            if (mc_cnt == 0) begin
               iMC_done = 1'b1;
               iMC_inst = mem_word(mc_lat_addr);
            end
         end else if (oMC_en) begin
            mc_reqs++;
            mc_lat_addr = oMC_addr;
            mc_cnt = MC_LAT;
            checkOutput("mc_addr", oMC_addr, exp_mc_addr);
         end
      end
   end

   // Delivery monitor: pops the scoreboard on every oIF_valid pulse
   initial begin
      logic [31:0] e_inst;
      forever begin
         @(negedge clk);
         if (oIF_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
               checkOutput("spurious_valid", {31'b0, oIF_valid}, 32'h0);
            end else begin
               e_inst = sb.pop_front();
               checkOutput("inst", oIF_inst, e_inst);
            end
         end
      end
   end

   // Full fetch: queue the expected word, hold the request until delivery
   task automatic applyStimulus(input logic [31:0] pc, input int exp_miss);
      int r0;
      int cyc;
      r0 = mc_reqs;
      exp_mc_addr = {pc[31:2], 2'b00};
      sb.push_back(mem_word(exp_mc_addr));
      iIF_en = 1'b1;
      iIF_pc = pc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!oIF_valid && cyc < 60);
      checkOutput("latency", cyc, (exp_miss != 0) ? (MC_LAT + 3) : 2);
      tick();
      iIF_en = 1'b0;
      checkOutput("miss_count", mc_reqs - r0, exp_miss);
   endtask

   // Wait (bounded) for the cache to raise its memctrl request
   task automatic waitMcEn();
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!oMC_en && cyc < 20);
      checkOutput("mc_en_up", {31'b0, oMC_en}, 32'h1);
   endtask

   // Miss cancelled by a flush, either mid-flight or together with iMC_done
   task automatic flushMiss(input logic [31:0] pc, input bit at_done);
      int r0;
      int v0;
      int cyc;
      r0 = mc_reqs;
      v0 = valid_cnt;
      exp_mc_addr = {pc[31:2], 2'b00};
      iIF_en = 1'b1;
      iIF_pc = pc;
      waitMcEn();
      if (!at_done) begin
         tick();
         iFlush = 1'b1;
         iIF_en = 1'b0;
         tick();
         iFlush = 1'b0;
         @(negedge clk);
         checkOutput("mc_en_held", {31'b0, oMC_en}, 32'h1);
      end else begin
         cyc = 0;
         while (!iMC_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
         end
         checkOutput("done_seen", {31'b0, iMC_done}, 32'h1);
         iFlush = 1'b1;
         iIF_en = 1'b0;
         tick();
         iFlush = 1'b0;
      end
      repeat (4) @(negedge clk);
      checkOutput("mc_en_down", {31'b0, oMC_en}, 32'h0);
      checkOutput("flush_no_valid", valid_cnt - v0, 0);
      checkOutput("flush_reqs", mc_reqs - r0, 1);
      tick();
   endtask

   // Hard stop in case the design wedges somewhere no bounded wait covers
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int v0;
      rst = 1'b1;
      rdy = 1'b1;
      iIF_en = 1'b0;
      iIF_pc = '0;
      iFlush = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_valid", {31'b0, oIF_valid}, 32'h0);
      checkOutput("rst_mc_en", {31'b0, oMC_en}, 32'h0);
      checkOutput("rst_mc_addr", oMC_addr, 32'h0);
      checkOutput("rst_inst", oIF_inst, 32'h0);
      tick();

      applyStimulus(32'h0000_0004, 1);
      applyStimulus(32'h0000_0004, 0);
      applyStimulus(32'h0000_0404, 1);
      applyStimulus(32'h0000_0004, 1);

      flushMiss(32'h0000_0100, 1'b0);
      applyStimulus(32'h0000_0100, 0);
      flushMiss(32'h0000_0200, 1'b1);
      applyStimulus(32'h0000_0200, 0);

      // Stall a pending delivery with rdy low for three cycles
      v0 = valid_cnt;
      exp_mc_addr = 32'h4;
      sb.push_back(mem_word(32'h4));
      iIF_en = 1'b1;
      iIF_pc = 32'h4;
      tick();
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("stall_valid", {31'b0, oIF_valid}, 32'h0);
         tick();
      end
      rdy = 1'b1;
      @(negedge clk);
      checkOutput("stall_release", {31'b0, oIF_valid}, 32'h1);
      tick();
      iIF_en = 1'b0;
      repeat (2) tick();
      checkOutput("stall_pulses", valid_cnt - v0, 1);

      // Flush in the delivery cycle swallows the pulse
      v0 = valid_cnt;
      iIF_en = 1'b1;
      iIF_pc = 32'h4;
      tick();
      iFlush = 1'b1;
      @(negedge clk);
      checkOutput("resp_flush_valid", {31'b0, oIF_valid}, 32'h0);
      tick();
      iFlush = 1'b0;
      iIF_en = 1'b0;
      repeat (2) tick();
      checkOutput("resp_flush_pulses", valid_cnt - v0, 0);

      applyStimulus(32'h0000_000B, 1);
      applyStimulus(32'h0000_0008, 0);
      applyStimulus(32'h0000_0009, 0);

      // Reset in the middle of a miss, then the cache must be cold again
      exp_mc_addr = 32'h300;
      iIF_en = 1'b1;
      iIF_pc = 32'h300;
      waitMcEn();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      iIF_en = 1'b0;
      @(negedge clk);
      checkOutput("miss_rst_mc_en", {31'b0, oMC_en}, 32'h0);
      checkOutput("miss_rst_valid", {31'b0, oIF_valid}, 32'h0);
      tick();
      applyStimulus(32'h0000_0004, 1);

      repeat (3) tick();
      checkOutput("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
